// File: rtl/trap_pkg.sv
// trap_pkg: shared types, interrupt cause codes and sizing helpers for the commit-stage trap controller.
package trap_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_SLEEP} state_t;
    typedef enum logic [1:0] {EV_NONE, EV_EXC, EV_MRET, EV_WFI} event_t;

    localparam int ECAUSE_WIDTH_DEF = 4;
    localparam int CAUSE_EIP = 11;
    localparam int CAUSE_TIP = 7;
    localparam int CAUSE_SIP = 3;

    function automatic int cnt_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    // pending is {eip,tip,sip}; external beats timer beats software
    function automatic int irq_cause(input logic [2:0] pending);
        return pending[2] ? CAUSE_EIP : pending[1] ? CAUSE_TIP : CAUSE_SIP;
    endfunction

endpackage

// File: rtl/commit_scan.sv
// commit_scan: finds the oldest valid lane carrying an exception, mret or wfi and counts valid lanes.
module commit_scan import trap_pkg::*; #(
    parameter int LANES = 2,
    parameter int LW    = 1,
    parameter int CW    = 2
) (
    input  logic [LANES-1:0] valid,
    input  logic [LANES-1:0] exp,
    input  logic [LANES-1:0] mret,
    input  logic [LANES-1:0] wfi,
    output logic             event_found,
    output logic [LW-1:0]    event_lane,
    output event_t           event_type,
    output logic [CW-1:0]    valid_cnt
);

    // descending walk so the lowest-index event is the last to write
    always_comb begin
        event_found = 1'b0;
        event_lane  = '0;
        event_type  = EV_NONE;
        valid_cnt   = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (valid[i] && (exp[i] || mret[i] || wfi[i])) begin
                event_found = 1'b1;
                event_lane  = LW'(i);
                event_type  = exp[i] ? EV_EXC : mret[i] ? EV_MRET : EV_WFI;
            end
        end
        for (int i = 0; i < LANES; i++)
            valid_cnt = valid_cnt + CW'(valid[i]);
    end

endmodule

// File: rtl/trap_ctrl_mc.sv
// trap_ctrl_mc: multi-lane commit-stage trap controller arbitrating interrupts, exceptions, mret and wfi,
// sequencing the post-trap flush and holding the core asleep on wfi.
module trap_ctrl_mc import trap_pkg::*; #(
    parameter int PC_WIDTH     = 32,
    parameter int COMMIT_WIDTH = 2,
    parameter int ECAUSE_WIDTH = ECAUSE_WIDTH_DEF,
    parameter int FLUSH_CYCLES = 2,
    localparam int CW = cnt_width(COMMIT_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [COMMIT_WIDTH-1:0]          cm_valid,
    input  logic [COMMIT_WIDTH*PC_WIDTH-1:0] cm_pc,
    input  logic [COMMIT_WIDTH-1:0]          cm_exp,
    input  logic [COMMIT_WIDTH*ECAUSE_WIDTH-1:0] cm_ecause,
    input  logic [COMMIT_WIDTH-1:0]          cm_mret,
    input  logic [COMMIT_WIDTH-1:0]          cm_wfi,
    input  logic [2:0]                       irq_pending,
    input  logic                             irq_en,
    output logic [CW-1:0]                    cm_accept_cnt,
    output logic [CW-1:0]                    retire_cnt,
    output logic                             trap_req,
    output logic                             trap_is_irq,
    output logic [ECAUSE_WIDTH-1:0]          trap_cause,
    output logic [PC_WIDTH-1:0]              trap_epc,
    output logic                             mret_req,
    output logic                             wake_req,
    output logic [PC_WIDTH-1:0]              wake_pc,
    output logic                             flush,
    output logic                             sleeping
);

    localparam int LW = COMMIT_WIDTH > 1 ? $clog2(COMMIT_WIDTH) : 1;
    localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;

    state_t                    state, state_d;
    logic [FW-1:0]             fcnt, fcnt_d;
    logic [PC_WIDTH-1:0]       saved_pc, saved_pc_d;
    logic                      trap_d, irq_d, mret_d, wake_d;
    logic [ECAUSE_WIDTH-1:0]   cause_d;
    logic [PC_WIDTH-1:0]       epc_d;
    logic [CW-1:0]             retire_d;
    logic [PC_WIDTH-1:0]       pc_l [COMMIT_WIDTH];
    logic [ECAUSE_WIDTH-1:0]   ec_l [COMMIT_WIDTH];
    logic                      ev_found;
    logic [LW-1:0]             ev_lane;
    event_t                    ev_type;
    logic [CW-1:0]             valid_cnt;
    logic [CW-1:0]             lane_cnt;
    logic                      irq_any;

    for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_lane
        assign pc_l[g] = cm_pc[g*PC_WIDTH +: PC_WIDTH];
        assign ec_l[g] = cm_ecause[g*ECAUSE_WIDTH +: ECAUSE_WIDTH];
    end

    commit_scan #(.LANES(COMMIT_WIDTH), .LW(LW), .CW(CW)) u_scan (
        .valid      (cm_valid),
        .exp        (cm_exp),
        .mret       (cm_mret),
        .wfi        (cm_wfi),
        .event_found(ev_found),
        .event_lane (ev_lane),
        .event_type (ev_type),
        .valid_cnt  (valid_cnt)
    );

    assign irq_any  = |irq_pending;
    assign lane_cnt = CW'(ev_lane);
    assign flush    = state == ST_FLUSH;
    assign sleeping = state == ST_SLEEP;
    assign wake_pc  = saved_pc;

    always_comb begin
        state_d       = state;
        fcnt_d        = fcnt;
        saved_pc_d    = saved_pc;
        trap_d        = 1'b0;
        irq_d         = 1'b0;
        cause_d       = '0;
        epc_d         = '0;
        mret_d        = 1'b0;
        wake_d        = 1'b0;
        retire_d      = '0;
        cm_accept_cnt = '0;
        case (state)
            ST_IDLE: begin
                if (irq_en && irq_any && cm_valid[0]) begin
                    trap_d  = 1'b1;
                    irq_d   = 1'b1;
                    cause_d = ECAUSE_WIDTH'(irq_cause(irq_pending));
                    epc_d   = pc_l[0];
                    state_d = ST_FLUSH;
                    fcnt_d  = FW'(FLUSH_CYCLES - 1);
                end else if (!ev_found) begin
                    cm_accept_cnt = valid_cnt;
                    retire_d      = valid_cnt;
                end else begin
                    // the excepting lane itself does not retire; mret and wfi do
                    cm_accept_cnt = ev_type == EV_EXC ? lane_cnt : lane_cnt + CW'(1);
                    retire_d      = cm_accept_cnt;
                    trap_d        = ev_type == EV_EXC;
                    cause_d       = ev_type == EV_EXC ? ec_l[ev_lane] : '0;
                    epc_d         = ev_type == EV_EXC ? pc_l[ev_lane] : '0;
                    mret_d        = ev_type == EV_MRET;
                    state_d       = ev_type == EV_WFI ? ST_SLEEP : ST_FLUSH;
                    fcnt_d        = FW'(FLUSH_CYCLES - 1);
                    saved_pc_d    = ev_type == EV_WFI ? pc_l[ev_lane] + PC_WIDTH'(4) : saved_pc;
                end
            end
            ST_FLUSH: begin
                state_d = fcnt == '0 ? ST_IDLE : ST_FLUSH;
                fcnt_d  = fcnt == '0 ? '0 : fcnt - FW'(1);
            end
            ST_SLEEP: begin
                // wake on any pending source; irq_en only chooses trap versus plain resume
                if (irq_any) begin
                    trap_d  = irq_en;
                    irq_d   = irq_en;
                    cause_d = irq_en ? ECAUSE_WIDTH'(irq_cause(irq_pending)) : '0;
                    epc_d   = irq_en ? saved_pc : '0;
                    wake_d  = !irq_en;
                    state_d = ST_FLUSH;
                    fcnt_d  = FW'(FLUSH_CYCLES - 1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            fcnt        <= '0;
            saved_pc    <= '0;
            trap_req    <= 1'b0;
            trap_is_irq <= 1'b0;
            trap_cause  <= '0;
            trap_epc    <= '0;
            mret_req    <= 1'b0;
            wake_req    <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            state       <= state_d;
            fcnt        <= fcnt_d;
            saved_pc    <= saved_pc_d;
            trap_req    <= trap_d;
            trap_is_irq <= irq_d;
            trap_cause  <= cause_d;
            trap_epc    <= epc_d;
            mret_req    <= mret_d;
            wake_req    <= wake_d;
            retire_cnt  <= retire_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl_mc.sv
// tb_trap_ctrl_mc: scoreboard bench for trap_ctrl_mc with COMMIT_WIDTH=2, FLUSH_CYCLES=2.
module tb_trap_ctrl_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cm_valid, cm_exp, cm_mret, cm_wfi;
    logic [63:0] cm_pc;
    logic [7:0]  cm_ecause;
    logic [2:0]  irq_pending;
    logic        irq_en;
    logic [1:0]  cm_accept_cnt, retire_cnt;
    logic        trap_req, trap_is_irq, mret_req, wake_req, flush, sleeping;
    logic [3:0]  trap_cause;
    logic [31:0] trap_epc, wake_pc;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        trap;
        logic        irq;
        logic [3:0]  cause;
        logic [31:0] epc;
        logic        mret;
        logic        wake;
        logic [1:0]  retire;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    trap_ctrl_mc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cm_valid     (cm_valid),
        .cm_pc        (cm_pc),
        .cm_exp       (cm_exp),
        .cm_ecause    (cm_ecause),
        .cm_mret      (cm_mret),
        .cm_wfi       (cm_wfi),
        .irq_pending  (irq_pending),
        .irq_en       (irq_en),
        .cm_accept_cnt(cm_accept_cnt),
        .retire_cnt   (retire_cnt),
        .trap_req     (trap_req),
        .trap_is_irq  (trap_is_irq),
        .trap_cause   (trap_cause),
        .trap_epc     (trap_epc),
        .mret_req     (mret_req),
        .wake_req     (wake_req),
        .wake_pc      (wake_pc),
        .flush        (flush),
        .sleeping     (sleeping)
    );

    function automatic exp_t observe();
        exp_t o;
        o.trap   = trap_req;
        o.irq    = trap_is_irq;
        o.cause  = trap_cause;
        o.epc    = trap_epc;
        o.mret   = mret_req;
        o.wake   = wake_req;
        o.retire = retire_cnt;
        return o;
    endfunction

    function automatic exp_t mk(input logic t, input logic i, input logic [3:0] c, input logic [31:0] pc,
                                input logic m, input logic w, input logic [1:0] r);
        exp_t e;
        e.trap = t; e.irq = i; e.cause = c; e.epc = pc; e.mret = m; e.wake = w; e.retire = r;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        cm_valid = '0; cm_exp = '0; cm_mret = '0; cm_wfi = '0;
        cm_pc = '0; cm_ecause = '0; irq_pending = '0; irq_en = 1'b0;
    endtask

    task automatic drive_lane(input int i, input logic [31:0] pc, input logic e, input logic [3:0] ec,
                              input logic m, input logic w);
        cm_valid[i] = 1'b1;
        cm_pc[i*32 +: 32] = pc;
        cm_exp[i] = e;
        cm_ecause[i*4 +: 4] = ec;
        cm_mret[i] = m;
        cm_wfi[i] = w;
    endtask

    task automatic test_reset();
        exp_t e;
        clear_in();
        #2;
        checks++;
        if ({trap_req, trap_is_irq, trap_cause, trap_epc, mret_req, wake_req, retire_cnt, flush, sleeping, wake_pc} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got trap=%b mret=%b wake=%b retire=%0d flush=%b sleep=%b want all 0",
                     trap_req, mret_req, wake_req, retire_cnt, flush, sleeping);
        end
        step();
        rst_n = 1'b1;
        step();
        e = observe();
        checks++;
        if (e !== '0) begin
            failures++;
            $display("FAIL post_reset_idle: got %h want 0", e);
        end
    endtask

    task automatic test_no_event();
        exp_t e;
        clear_in();
        drive_lane(0, 32'h10, 0, 0, 0, 0);
        drive_lane(1, 32'h14, 0, 0, 0, 0);
        #1;
        checks++;
        if (cm_accept_cnt !== 2'd2) begin
            failures++;
            $display("FAIL no_event_accept: got %0d want 2", cm_accept_cnt);
        end
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 2));
        step();
        clear_in();
        e = sb.pop_front();
        checks++;
        if (observe() !== e) begin
            failures++;
            $display("FAIL no_event_retire: got %h want %h", observe(), e);
        end
    endtask

    task automatic test_exception();
        exp_t e;
        clear_in();
        drive_lane(0, 32'h100, 0, 0, 0, 0);
        drive_lane(1, 32'h104, 1, 4'd2, 0, 0);
        #1;
        checks++;
        if (cm_accept_cnt !== 2'd1) begin
            failures++;
            $display("FAIL exc_accept: got %0d want 1", cm_accept_cnt);
        end
        sb.push_back(mk(1, 0, 4'd2, 32'h104, 0, 0, 1));
        step();
        cm_exp = '0;
        e = sb.pop_front();
        checks++;
        if (observe() !== e) begin
            failures++;
            $display("FAIL exc_pulse: got %h want %h", observe(), e);
        end
        checks++;
        if (flush !== 1'b1 || cm_accept_cnt !== 2'd0) begin
            failures++;
            $display("FAIL exc_flush1: got flush=%b accept=%0d want 1/0", flush, cm_accept_cnt);
        end
        step();
        checks++;
        if (flush !== 1'b1 || cm_accept_cnt !== 2'd0 || trap_req !== 1'b0 || retire_cnt !== 2'd0) begin
            failures++;
            $display("FAIL exc_flush2: got flush=%b accept=%0d trap=%b retire=%0d want 1/0/0/0",
                     flush, cm_accept_cnt, trap_req, retire_cnt);
        end
        step();
        checks++;
        if (flush !== 1'b0 || cm_accept_cnt !== 2'd2) begin
            failures++;
            $display("FAIL exc_flush_end: got flush=%b accept=%0d want 0/2", flush, cm_accept_cnt);
        end
        clear_in();
        step();
    endtask

    task automatic test_irq();
        exp_t e;
        logic [2:0] pend [3];
        logic [3:0] cause [3];
        pend[0] = 3'b111; cause[0] = 4'd11;
        pend[1] = 3'b011; cause[1] = 4'd7;
        pend[2] = 3'b001; cause[2] = 4'd3;
        for (int k = 0; k < 3; k++) begin
            clear_in();
            irq_en = 1'b1;
            irq_pending = pend[k];
            drive_lane(0, 32'h200, 0, 0, 0, 0);
            drive_lane(1, 32'h204, 1, 4'd2, 0, 0);
            #1;
            checks++;
            if (cm_accept_cnt !== 2'd0) begin
                failures++;
                $display("FAIL irq_accept[%0d]: got %0d want 0", k, cm_accept_cnt);
            end
            sb.push_back(mk(1, 1, cause[k], 32'h200, 0, 0, 0));
            step();
            clear_in();
            e = sb.pop_front();
            checks++;
            if (observe() !== e) begin
                failures++;
                $display("FAIL irq_pulse[%0d]: got %h want %h", k, observe(), e);
            end
            step();
            step();
        end
        clear_in();
        irq_en = 1'b1;
        irq_pending = 3'b100;
        #1;
        step();
        checks++;
        if (trap_req !== 1'b0 || flush !== 1'b0) begin
            failures++;
            $display("FAIL irq_no_lane0: got trap=%b flush=%b want 0/0", trap_req, flush);
        end
        irq_en = 1'b0;
        drive_lane(0, 32'h220, 0, 0, 0, 0);
        drive_lane(1, 32'h224, 0, 0, 0, 0);
        #1;
        checks++;
        if (cm_accept_cnt !== 2'd2) begin
            failures++;
            $display("FAIL irq_masked_accept: got %0d want 2", cm_accept_cnt);
        end
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 2));
        step();
        clear_in();
        e = sb.pop_front();
        checks++;
        if (observe() !== e) begin
            failures++;
            $display("FAIL irq_masked_retire: got %h want %h", observe(), e);
        end
    endtask

    task automatic test_wfi();
        exp_t e;
        clear_in();
        drive_lane(0, 32'hFFFF_FFFC, 0, 0, 0, 1);
        drive_lane(1, 32'h0, 0, 0, 0, 0);
        #1;
        checks++;
        if (cm_accept_cnt !== 2'd1) begin
            failures++;
            $display("FAIL wfi_accept: got %0d want 1", cm_accept_cnt);
        end
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        step();
        cm_wfi = '0;
        e = sb.pop_front();
        checks++;
        if (observe() !== e) begin
            failures++;
            $display("FAIL wfi_retire: got %h want %h", observe(), e);
        end
        checks++;
        if (sleeping !== 1'b1 || cm_accept_cnt !== 2'd0) begin
            failures++;
            $display("FAIL wfi_sleep: got sleeping=%b accept=%0d want 1/0", sleeping, cm_accept_cnt);
        end
        step();
        checks++;
        if (sleeping !== 1'b1 || retire_cnt !== 2'd0) begin
            failures++;
            $display("FAIL wfi_hold: got sleeping=%b retire=%0d want 1/0", sleeping, retire_cnt);
        end
        irq_pending = 3'b100;
        sb.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        step();
        clear_in();
        e = sb.pop_front();
        checks++;
        if (observe() !== e || wake_pc !== 32'h0) begin
            failures++;
            $display("FAIL wfi_wake: got %h pc=%h want %h pc=0", observe(), wake_pc, e);
        end
        checks++;
        if (flush !== 1'b1 || sleeping !== 1'b0) begin
            failures++;
            $display("FAIL wake_flush1: got flush=%b sleeping=%b want 1/0", flush, sleeping);
        end
        step();
        checks++;
        if (flush !== 1'b1 || wake_req !== 1'b0) begin
            failures++;
            $display("FAIL wake_flush2: got flush=%b wake=%b want 1/0", flush, wake_req);
        end
        step();
        checks++;
        if (flush !== 1'b0) begin
            failures++;
            $display("FAIL wake_flush_end: got flush=%b want 0", flush);
        end
        drive_lane(0, 32'h300, 0, 0, 0, 0);
        drive_lane(1, 32'h304, 0, 0, 0, 1);
        #1;
        checks++;
        if (cm_accept_cnt !== 2'd2) begin
            failures++;
            $display("FAIL wfi1_accept: got %0d want 2", cm_accept_cnt);
        end
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 2));
        step();
        clear_in();
        e = sb.pop_front();
        checks++;
        if (observe() !== e || sleeping !== 1'b1) begin
            failures++;
            $display("FAIL wfi1_retire: got %h sleeping=%b want %h sleeping=1", observe(), sleeping, e);
        end
        irq_en = 1'b1;
        irq_pending = 3'b010;
        sb.push_back(mk(1, 1, 4'd7, 32'h308, 0, 0, 0));
        step();
        clear_in();
        e = sb.pop_front();
        checks++;
        if (observe() !== e) begin
            failures++;
            $display("FAIL wfi1_irq_trap: got %h want %h", observe(), e);
        end
        step();
        step();
    endtask

    task automatic test_mret();
        exp_t e;
        clear_in();
        drive_lane(0, 32'h500, 0, 0, 1, 0);
        drive_lane(1, 32'h504, 0, 0, 0, 0);
        #1;
        checks++;
        if (cm_accept_cnt !== 2'd1) begin
            failures++;
            $display("FAIL mret_accept: got %0d want 1", cm_accept_cnt);
        end
        sb.push_back(mk(0, 0, 0, 0, 1, 0, 1));
        step();
        clear_in();
        e = sb.pop_front();
        checks++;
        if (observe() !== e || flush !== 1'b1) begin
            failures++;
            $display("FAIL mret_pulse: got %h flush=%b want %h flush=1", observe(), flush, e);
        end
        step();
        step();
        checks++;
        if (flush !== 1'b0 || mret_req !== 1'b0) begin
            failures++;
            $display("FAIL mret_flush_end: got flush=%b mret=%b want 0/0", flush, mret_req);
        end
    endtask

    task automatic test_priority();
        exp_t e;
        clear_in();
        drive_lane(0, 32'h400, 1, 4'd5, 1, 0);
        drive_lane(1, 32'h404, 0, 0, 0, 1);
        #1;
        checks++;
        if (cm_accept_cnt !== 2'd0) begin
            failures++;
            $display("FAIL prio_exc_accept: got %0d want 0", cm_accept_cnt);
        end
        sb.push_back(mk(1, 0, 4'd5, 32'h400, 0, 0, 0));
        step();
        clear_in();
        e = sb.pop_front();
        checks++;
        if (observe() !== e) begin
            failures++;
            $display("FAIL prio_exc_pulse: got %h want %h", observe(), e);
        end
        step();
        step();
        drive_lane(0, 32'h600, 0, 0, 0, 1);
        drive_lane(1, 32'h604, 1, 4'd9, 0, 0);
        #1;
        checks++;
        if (cm_accept_cnt !== 2'd1) begin
            failures++;
            $display("FAIL prio_wfi_accept: got %0d want 1", cm_accept_cnt);
        end
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        step();
        clear_in();
        e = sb.pop_front();
        checks++;
        if (observe() !== e || sleeping !== 1'b1 || wake_pc !== 32'h604) begin
            failures++;
            $display("FAIL prio_wfi_sleep: got %h sleeping=%b pc=%h want %h sleeping=1 pc=604",
                     observe(), sleeping, wake_pc, e);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        checks++;
        if (sleeping !== 1'b0 || flush !== 1'b0 || wake_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_sleep: got sleeping=%b flush=%b pc=%h want 0/0/0", sleeping, flush, wake_pc);
        end
        step();
        rst_n = 1'b1;
        step();
        drive_lane(0, 32'h700, 0, 0, 1, 0);
        #1;
        step();
        clear_in();
        checks++;
        if (flush !== 1'b1 || mret_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_flush: got flush=%b mret=%b want 1/1", flush, mret_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({flush, sleeping, trap_req, mret_req, wake_req, retire_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_mid_flush: got flush=%b sleep=%b trap=%b mret=%b wake=%b retire=%0d want all 0",
                     flush, sleeping, trap_req, mret_req, wake_req, retire_cnt);
        end
        step();
        rst_n = 1'b1;
        drive_lane(0, 32'h800, 0, 0, 0, 0);
        drive_lane(1, 32'h804, 0, 0, 0, 0);
        #1;
        checks++;
        if (cm_accept_cnt !== 2'd2) begin
            failures++;
            $display("FAIL reset_resume_accept: got %0d want 2", cm_accept_cnt);
        end
        step();
        clear_in();
        checks++;
        if (retire_cnt !== 2'd2) begin
            failures++;
            $display("FAIL reset_resume_retire: got %0d want 2", retire_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_no_event();
        test_exception();
        test_irq();
        test_wfi();
        test_mret();
        test_priority();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
